scr1_mem_arb2: RTL

Two-port memory-interface arbiter that shares one downstream core memory port (in front of a single AHB bridge) between the instruction-fetch requester (IMEM, read-only) and the load/store requester (DMEM, read/write). It grants at most one request per cycle using round-robin, and records the owner of every accepted request in an in-order ID FIFO. Each response is routed back to the requester that issued it. Used in single-AHB-port configurations where the core's IMEM and DMEM traffic must merge before the bus bridge.

---
 rtl/scr1_mem_arb2_pkg.sv | 43 ++++
 rtl/scr1_mem_arb_idfifo.sv | 66 ++++++
 rtl/scr1_mem_arb2.sv | 136 +++++++++++++
 3 files changed

// File: rtl/scr1_mem_arb2_pkg.sv
// Shared memory-interface types for the two-port IMEM/DMEM arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package scr1_mem_arb2_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Owner tag recorded for every accepted downstream request
  typedef enum logic {
    SCR1_ARB_ID_IMEM = 1'b0,
    SCR1_ARB_ID_DMEM = 1'b1
  } type_scr1_mem_arb_id_e;

  // Downstream request fields, muxed as one bundle from the winner
  typedef struct packed {
    type_scr1_mem_cmd_e        cmd;
    type_scr1_mem_width_e      width;
    logic [SCR1_AHB_WIDTH-1:0] addr;
    logic [SCR1_AHB_WIDTH-1:0] wdata;
  } type_scr1_mem_req_s;

  function automatic type_scr1_mem_arb_id_e scr1_arb_other(input type_scr1_mem_arb_id_e id);
    return (id == SCR1_ARB_ID_IMEM) ? SCR1_ARB_ID_DMEM : SCR1_ARB_ID_IMEM;
  endfunction

endpackage

// File: rtl/scr1_mem_arb_idfifo.sv
// In-order owner-ID FIFO: remembers which requester issued each outstanding request.
// Latency: push visible at head one cycle later; head_id/full/empty are registered-state decodes.
// Backpressure: push ignored while full, pop ignored while empty; caller gates grants on full.
//
// Ports: clk, rst_n (async active-low); push/push_id write side; pop/head_id read side;
//        full/empty status.
module scr1_mem_arb_idfifo
  import scr1_mem_arb2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  type_scr1_mem_arb_id_e push_id,
  input  logic                  pop,
  output type_scr1_mem_arb_id_e head_id,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] ids;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = type_scr1_mem_arb_id_e'(ids[rd_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ids    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the count unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scr1_mem_arb2.sv
// Round-robin arbiter merging IMEM (read-only) and DMEM traffic onto one memory port.
// Latency: zero on both paths; req->mem_req and mem_resp->owner resp are combinational.
// Backpressure: mem_req_ack passes straight to the winner; no grants while the ID FIFO is full.
//
// Ports: clk, rst_n (async active-low); imem_* fetch requester; dmem_* load/store
//        requester; mem_* shared downstream port toward the AHB bridge.
module scr1_mem_arb2
  import scr1_mem_arb2_pkg::*;
#(
  parameter int SCR1_ARB_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // IMEM requester
  input  logic                      imem_req,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_addr,
  output logic                      imem_req_ack,
  output logic [SCR1_AHB_WIDTH-1:0] imem_rdata,
  output type_scr1_mem_resp_e       imem_resp,
  // DMEM requester
  input  logic                      dmem_req,
  input  type_scr1_mem_cmd_e        dmem_cmd,
  input  type_scr1_mem_width_e      dmem_width,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_wdata,
  output logic                      dmem_req_ack,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e       dmem_resp,
  // Shared downstream port
  output logic                      mem_req,
  output type_scr1_mem_cmd_e        mem_cmd,
  output type_scr1_mem_width_e      mem_width,
  output logic [SCR1_AHB_WIDTH-1:0] mem_addr,
  output logic [SCR1_AHB_WIDTH-1:0] mem_wdata,
  input  logic                      mem_req_ack,
  input  logic [SCR1_AHB_WIDTH-1:0] mem_rdata,
  input  type_scr1_mem_resp_e       mem_resp
);

  type_scr1_mem_arb_id_e last_grant;
  type_scr1_mem_arb_id_e win_id;
  type_scr1_mem_arb_id_e head_id;
  type_scr1_mem_req_s    imem_fields;
  type_scr1_mem_req_s    dmem_fields;
  type_scr1_mem_req_s    mem_fields;
  logic                  imem_elig;
  logic                  dmem_elig;
  logic                  win_vld;
  logic                  accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  // Eligibility looks only at full, not full-and-popping, so there is no
  // combinational path from mem_resp to either req_ack.
  assign imem_elig = imem_req & ~fifo_full;
  assign dmem_elig = dmem_req & ~fifo_full;

  always_comb begin
    win_vld = imem_elig | dmem_elig;
    win_id  = SCR1_ARB_ID_IMEM;
    if (imem_elig & dmem_elig) begin
      win_id = scr1_arb_other(last_grant);
    end else if (dmem_elig) begin
      win_id = SCR1_ARB_ID_DMEM;
    end
  end

  // Fetches are always full-word reads with no write data
  assign imem_fields = '{cmd: SCR1_MEM_CMD_RD, width: SCR1_MEM_WIDTH_WORD,
                         addr: imem_addr, wdata: '0};
  assign dmem_fields = '{cmd: dmem_cmd, width: dmem_width,
                         addr: dmem_addr, wdata: dmem_wdata};
  assign mem_fields  = (win_id == SCR1_ARB_ID_DMEM) ? dmem_fields : imem_fields;

  assign mem_req   = win_vld;
  assign mem_cmd   = mem_fields.cmd;
  assign mem_width = mem_fields.width;
  assign mem_addr  = mem_fields.addr;
  assign mem_wdata = mem_fields.wdata;

  assign accept       = win_vld & mem_req_ack;
  assign imem_req_ack = accept & (win_id == SCR1_ARB_ID_IMEM);
  assign dmem_req_ack = accept & (win_id == SCR1_ARB_ID_DMEM);

  // Reset to DMEM so IMEM wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SCR1_ARB_ID_DMEM;
    end else if (accept) begin
      last_grant <= win_id;
    end
  end

  // A response with nothing outstanding (e.g. in flight across a reset) is dropped
  assign fifo_pop = (mem_resp != SCR1_MEM_RESP_NOTRDY) & ~fifo_empty;

  scr1_mem_arb_idfifo #(
    .DEPTH (SCR1_ARB_DEPTH)
  ) u_idfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (win_id),
    .pop     (fifo_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    imem_resp = SCR1_MEM_RESP_NOTRDY;
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    if (fifo_pop) begin
      if (head_id == SCR1_ARB_ID_IMEM) begin
        imem_resp = mem_resp;
      end else begin
        dmem_resp = mem_resp;
      end
    end
  end

  // Read data is only meaningful alongside a non-NOTRDY resp
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

`ifdef SCR1_SIM_ENV
  a_no_x_inputs : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({imem_req, dmem_req, mem_resp}));
  a_no_resp_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    (mem_resp != SCR1_MEM_RESP_NOTRDY) |-> !fifo_empty);
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> !fifo_full);
`endif

endmodule
